// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation and state
// encodings plus the default datapath width.
package rv_mdu_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_CALC = 2'b01,
    DIV_ST_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes:
// shift {rem, quo} left, trial-subtract the divisor, keep it when non-negative.
module div_step
  import rv_mdu_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor always holds, so XLEN+1 bits cover both the shifted value and the sign of the trial
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_nxt = shifted[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_nxt = trial[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow in one cycle.
module mdu_divider
  import rv_mdu_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            DIV_flush,
  input  logic            DIV_start_valid,
  output logic            DIV_start_ready,
  input  logic [1:0]      DIV_op,
  input  logic [XLEN-1:0] DIV_dividend,
  input  logic [XLEN-1:0] DIV_divisor,
  output logic            DIV_result_valid,
  input  logic            DIV_result_ready,
  output logic [XLEN-1:0] DIV_result,
  output logic            DIV_busy
);

  localparam int                CNT_W     = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]   MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, dvd_q, res_q;
  logic [XLEN-1:0]  rem_nxt, quo_nxt;
  div_op_e          op_q;
  logic             q_neg_q, r_neg_q, div0_q, ovf_q;

  div_op_e          op_in;
  logic             sgn_in, div0_in, ovf_in, accept;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  // Sign correction first, then the RV32M special cases override it
  function automatic logic [XLEN-1:0] fixup(
    input div_op_e         op,
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag,
    input logic [XLEN-1:0] dvd,
    input logic            q_neg,
    input logic            r_neg,
    input logic            div0,
    input logic            ovf
  );
    logic            is_rem;
    logic [XLEN-1:0] q, r;
    is_rem = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    q = q_neg ? -q_mag : q_mag;
    r = r_neg ? -r_mag : r_mag;
    if (div0) begin
      q = '1;
      r = dvd;
    end else if (ovf) begin
      q = MIN_NEG;
      r = '0;
    end
    return is_rem ? r : q;
  endfunction

  assign op_in   = div_op_e'(DIV_op);
  assign sgn_in  = !DIV_op[0];
  assign div0_in = (DIV_divisor == '0);
  assign ovf_in  = sgn_in && (DIV_dividend == MIN_NEG) && (DIV_divisor == '1);
  assign accept  = DIV_start_valid && (state_q == DIV_ST_IDLE) && !DIV_flush;

`ifdef DIV_FAST_SPECIAL_EN
  logic special_in;
  assign special_in = div0_in || ovf_in;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) state_q <= DIV_ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_ST_IDLE: begin
`ifdef DIV_FAST_SPECIAL_EN
        if (accept) state_d = special_in ? DIV_ST_DONE : DIV_ST_CALC;
`else
        if (accept) state_d = DIV_ST_CALC;
`endif
      end
      DIV_ST_CALC: if (cnt_q == LAST_STEP) state_d = DIV_ST_DONE;
      DIV_ST_DONE: if (DIV_result_ready) state_d = DIV_ST_IDLE;
      default:     state_d = DIV_ST_IDLE;
    endcase
    if (DIV_flush) state_d = DIV_ST_IDLE;
  end

  // Stage boundary: operand capture at acceptance, one iteration per CALC cycle, fixup on the last
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      res_q   <= '0;
      op_q    <= DIV_OP_DIV;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= magnitude(DIV_dividend, sgn_in);
      dvsr_q  <= magnitude(DIV_divisor, sgn_in);
      dvd_q   <= DIV_dividend;
      op_q    <= op_in;
      q_neg_q <= sgn_in && (DIV_dividend[XLEN-1] ^ DIV_divisor[XLEN-1]);
      r_neg_q <= sgn_in && DIV_dividend[XLEN-1];
      div0_q  <= div0_in;
      ovf_q   <= ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
      if (special_in)
        res_q <= fixup(op_in, '0, '0, DIV_dividend, 1'b0, 1'b0, div0_in, ovf_in);
`endif
    end else if ((state_q == DIV_ST_CALC) && !DIV_flush) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP)
        res_q <= fixup(op_q, quo_nxt, rem_nxt, dvd_q, q_neg_q, r_neg_q, div0_q, ovf_q);
    end
  end

  assign DIV_start_ready  = (state_q == DIV_ST_IDLE);
  assign DIV_result_valid = (state_q == DIV_ST_DONE);
  assign DIV_busy         = (state_q != DIV_ST_IDLE);
  assign DIV_result       = res_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider: reference results are queued at issue and
// popped by a monitor on each result handshake.
module tb_mdu_divider;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  // Edges after the acceptance edge until DIV_result_valid is seen high
  localparam int NORMAL_LAT = 32;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        sv = 1'b0;
  logic        sr;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rv;
  logic        rr = 1'b1;
  logic [31:0] res;
  logic        busy;

  logic [31:0] sb[$];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mdu_divider dut (
    .SYS_clk          (clk),
    .SYS_reset        (rst_n),
    .DIV_flush        (flush),
    .DIV_start_valid  (sv),
    .DIV_start_ready  (sr),
    .DIV_op           (op),
    .DIV_dividend     (a),
    .DIV_divisor      (b),
    .DIV_result_valid (rv),
    .DIV_result_ready (rr),
    .DIV_result       (res),
    .DIV_busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic        is_rem;
    logic signed [31:0] sx, sy;
    is_rem = o[1];
    sx = x;
    sy = y;
    if (y == 32'd0) return is_rem ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == MIN_NEG && y == 32'hFFFF_FFFF) return is_rem ? 32'd0 : MIN_NEG;
      return is_rem ? 32'(sx % sy) : 32'(sx / sy);
    end
    return is_rem ? (x % y) : (x / y);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (!o[0] && x == MIN_NEG && y == 32'hFFFF_FFFF);
  endfunction

  always @(negedge clk) begin
    if (rst_n && rv && rr) begin
      if (sb.size() == 0) chk("unexpected_result", {31'd0, rv}, 32'd0);
      else                chk("result", res, sb.pop_front());
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    sv = 1'b1;
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1 sv = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!rv && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int c;
    issue(o, x, y);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_valid(c);
    chk({tag, "_lat"}, c, is_special(o, x, y) ? SPECIAL_LAT : NORMAL_LAT);
    @(posedge clk);
    #1 chk({tag, "_ready_after"}, {31'd0, sr}, 32'd1);
  endtask

  initial begin
    int          c;
    int          seen;
    logic [31:0] held;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", {31'd0, sr}, 32'd1);
    chk("rst_result_valid", {31'd0, rv}, 32'd0);
    chk("rst_result", res, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run(2'b00, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
    run(2'b10, 32'd100, 32'hFFFF_FFF9, "rem_100_m7");
    run(2'b01, 32'hFFFF_FFFF, 32'd2, "divu_max_2");
    run(2'b10, 32'hFFFF_FFF9, 32'd3, "rem_m7_3");
    run(2'b11, 32'hFFFF_FFF9, 32'd3, "remu_big_3");
    run(2'b00, 32'd5, 32'd0, "div_by0");
    run(2'b11, 32'd5, 32'd0, "remu_by0");
    run(2'b10, 32'hFFFF_FFF9, 32'd0, "rem_neg_by0");
    run(2'b00, MIN_NEG, 32'hFFFF_FFFF, "div_ovf");
    run(2'b10, MIN_NEG, 32'hFFFF_FFFF, "rem_ovf");
    run(2'b01, MIN_NEG, 32'hFFFF_FFFF, "divu_min_max");

    // Consumer stalls: result must hold and new starts must be refused
    rr = 1'b0;
    issue(2'b01, 32'd1000, 32'd7);
    wait_valid(c);
    chk("hold_lat", c, NORMAL_LAT);
    held = res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = 2'b01;
      a  = 32'd50;
      b  = 32'd5;
      sv = 1'b1;
      chk("hold_valid", {31'd0, rv}, 32'd1);
      chk("hold_stable", res, held);
      chk("hold_start_ready", {31'd0, sr}, 32'd0);
    end
    @(posedge clk);
    #1;
    sv = 1'b0;
    rr = 1'b1;
    @(posedge clk);
    #1 chk("hold_ready_after", {31'd0, sr}, 32'd1);

    // Flush at iteration 10
    issue(2'b00, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(sb.pop_back());
    chk("flush_valid", {31'd0, rv}, 32'd0);
    chk("flush_start_ready", {31'd0, sr}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) @(negedge clk) if (rv) seen++;
    chk("flush_no_result", seen, 0);
    run(2'b01, 32'd9, 32'd3, "divu_after_flush");

    // Asynchronous reset mid-CALC
    issue(2'b00, 32'd1234, 32'd5);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_start_ready", {31'd0, sr}, 32'd1);
    chk("midrst_result_valid", {31'd0, rv}, 32'd0);
    chk("midrst_result", res, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk) rst_n = 1'b1;
    run(2'b00, 32'd7, 32'd2, "div_after_reset");

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  ro;
      logic [31:0] rx, ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run(ro, rx, ry, "rand");
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
